// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control unit: datapath selector
// codes, FSM states, opcodes and opcode classes.
package multicycle_control_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_OPC  = 2'b10;
  localparam logic [1:0] SRCA_ZERO = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] PCSRC_PC4  = 2'b00;
  localparam logic [1:0] PCSRC_TGT  = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LUI, C_AUIPC,
    C_LOAD, C_STORE, C_BRANCH, C_JAL,
    C_JALR, C_FENCE, C_SYSTEM, C_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic [1:0] wb_sel;
    logic       ir_wr;
    logic       pc_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       halted;
  } ctrl_t;

  function automatic logic is_mem(cls_e c);
    return (c == C_LOAD) || (c == C_STORE);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps the 7-bit opcode onto an instruction class; anything not
// recognised is flagged illegal.
module opcode_classifier
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_e       class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o = C_ILLEGAL;
    unique case (opcode_i)
      OPC_OP:     class_o = C_OP;
      OPC_OPIMM:  class_o = C_OPIMM;
      OPC_LUI:    class_o = C_LUI;
      OPC_AUIPC:  class_o = C_AUIPC;
      OPC_LOAD:   class_o = C_LOAD;
      OPC_STORE:  class_o = C_STORE;
      OPC_BRANCH: class_o = C_BRANCH;
      OPC_JAL:    class_o = C_JAL;
      OPC_JALR:   class_o = C_JALR;
      OPC_FENCE:  class_o = C_FENCE;
      OPC_SYSTEM: class_o = C_SYSTEM;
      default:    class_o = C_ILLEGAL;
    endcase
  end

  assign illegal_o = (class_o == C_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM with a retired-instruction counter.
// Opcode class is captured in DECODE and steers EXEC/MEM/WB.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  Opcode,
  input  logic        MemReady,
  input  logic        BranchTaken,
  output logic [1:0]  AluOp,
  output logic [1:0]  AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic        IrWrite,
  output logic        PcWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  PcSrc,
  output logic [1:0]  WbSel,
  output logic        Halted,
  output logic [2:0]  State,
  output logic [31:0] InstRetired
);

  state_e      state_q, state_d;
  cls_e        cls_q, dec_cls;
  logic        dec_illegal;
  logic        retire;
  logic [31:0] cnt_q, cnt_d;
  ctrl_t       ctrl;

  opcode_classifier u_cls (
    .opcode_i  (Opcode),
    .class_o   (dec_cls),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_OP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (MemReady) state_d = S_DECODE;
      S_DECODE:
        if (dec_illegal || dec_cls == C_SYSTEM) state_d = S_HALT;
        else if (dec_cls == C_FENCE)           state_d = S_FETCH;
        else                                   state_d = S_EXEC;
      S_EXEC:
        if (cls_q == C_BRANCH)   state_d = S_FETCH;
        else if (is_mem(cls_q))  state_d = S_MEM;
        else                     state_d = S_WB;
      S_MEM:
        if (MemReady)
          state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Every path back into FETCH completes an instruction; HALT never returns.
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);
  assign cnt_d  = retire ? cnt_q + 32'd1 : cnt_q;

  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.mem_rd = 1'b1;
      ctrl.src_a  = SRCA_PC;
      ctrl.src_b  = SRCB_FOUR;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          ctrl.mem_rd = 1'b1;
          ctrl.src_a  = SRCA_PC;
          ctrl.src_b  = SRCB_FOUR;
          ctrl.ir_wr  = MemReady;
          ctrl.pc_wr  = MemReady;
        end
        S_EXEC: begin
          unique case (cls_q)
            C_OP: ctrl.alu_op = ALU_FUNCT;
            C_OPIMM: begin
              ctrl.src_b  = SRCB_IMM;
              ctrl.alu_op = ALU_FUNCT;
            end
            C_LUI: begin
              ctrl.src_a = SRCA_ZERO;
              ctrl.src_b = SRCB_IMM;
            end
            C_AUIPC: begin
              ctrl.src_a = SRCA_OPC;
              ctrl.src_b = SRCB_IMM;
            end
            C_LOAD, C_STORE: ctrl.src_b = SRCB_IMM;
            C_BRANCH: begin
              ctrl.alu_op = ALU_SUB;
              ctrl.pc_wr  = BranchTaken;
              ctrl.pc_src = BranchTaken ? PCSRC_TGT : PCSRC_PC4;
            end
            C_JAL: begin
              ctrl.src_a  = SRCA_OPC;
              ctrl.src_b  = SRCB_IMM;
              ctrl.pc_wr  = 1'b1;
              ctrl.pc_src = PCSRC_TGT;
            end
            C_JALR: begin
              ctrl.src_b  = SRCB_IMM;
              ctrl.pc_wr  = 1'b1;
              ctrl.pc_src = PCSRC_JALR;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ctrl.src_b  = SRCB_IMM;
          ctrl.mem_rd = (cls_q == C_LOAD);
          ctrl.mem_wr = (cls_q == C_STORE);
        end
        S_WB: begin
          ctrl.reg_wr = 1'b1;
          unique case (1'b1)
            cls_q == C_LOAD:                      ctrl.wb_sel = WB_MEM;
            cls_q == C_JAL || cls_q == C_JALR:    ctrl.wb_sel = WB_PC4;
            default:                              ctrl.wb_sel = WB_ALU;
          endcase
        end
        S_HALT:  ctrl.halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign AluOp       = ctrl.alu_op;
  assign AluSrcA     = ctrl.src_a;
  assign AluSrcB     = ctrl.src_b;
  assign IrWrite     = ctrl.ir_wr;
  assign PcWrite     = ctrl.pc_wr;
  assign MemRead     = ctrl.mem_rd;
  assign MemWrite    = ctrl.mem_wr;
  assign RegWrite    = ctrl.reg_wr;
  assign PcSrc       = ctrl.pc_src;
  assign WbSel       = ctrl.wb_sel;
  assign Halted      = ctrl.halted;
  assign State       = state_q;
  assign InstRetired = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle bench for multicycle_control: table of per-cycle
// stimulus and expected controls, checked through a scoreboard queue.
module tb_multicycle_control;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] FEN = 7'b0001111;
  localparam logic [6:0] SYS = 7'b1110011;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2;
  localparam logic [2:0] M = 3'd3, W = 3'd4, H = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pw, mr, mw, rw;
    logic [1:0] ps, wb, ao, sa, sb;
    logic       h;
  } exp_t;

  typedef struct {
    string       n;
    logic        r;
    logic [6:0]  opc;
    logic        mrdy;
    logic        bt;
    exp_t        e;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  Opcode = '0;
  logic        MemReady = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [1:0]  AluOp, AluSrcA, AluSrcB, PcSrc, WbSel;
  logic        IrWrite, PcWrite, MemRead, MemWrite, RegWrite, Halted;
  logic [2:0]  State;
  logic [31:0] InstRetired;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  vec_t sb_q[$];

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .BranchTaken (BranchTaken),
    .AluOp       (AluOp),
    .AluSrcA     (AluSrcA),
    .AluSrcB     (AluSrcB),
    .IrWrite     (IrWrite),
    .PcWrite     (PcWrite),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .PcSrc       (PcSrc),
    .WbSel       (WbSel),
    .Halted      (Halted),
    .State       (State),
    .InstRetired (InstRetired)
  );

  always #5 clk = ~clk;

  // en = {IrWrite, PcWrite, MemRead, MemWrite, RegWrite}
  function automatic vec_t v(string n, logic r, logic [6:0] opc,
                             logic mrdy, logic bt, logic [2:0] st,
                             logic [4:0] en, logic [1:0] ps,
                             logic [1:0] wb, logic [1:0] ao,
                             logic [1:0] sa, logic [1:0] sb,
                             logic [31:0] cnt);
    vec_t t;
    t.n = n; t.r = r; t.opc = opc; t.mrdy = mrdy; t.bt = bt;
    t.e = {st, en, ps, wb, ao, sa, sb, (st == H) && !r};
    t.cnt = cnt;
    return t;
  endfunction

  function automatic vec_t fe(string n, logic [6:0] opc,
                              logic mrdy, logic [31:0] cnt);
    return v(n, 0, opc, mrdy, 0, F, mrdy ? 5'b11100 : 5'b00100,
             0, 0, 0, 1, 2, cnt);
  endfunction

  function automatic vec_t de(string n, logic [6:0] opc,
                              logic [31:0] cnt);
    return v(n, 0, opc, 1, 0, D, 5'b00000, 0, 0, 0, 0, 0, cnt);
  endfunction

  task automatic check();
    vec_t t;
    exp_t act;
    t = sb_q.pop_front();
    act = {State, IrWrite, PcWrite, MemRead, MemWrite, RegWrite,
           PcSrc, WbSel, AluOp, AluSrcA, AluSrcB, Halted};
    tests++;
    if (act !== t.e) begin
      fails++;
      $display("FAIL %s ctrl: got %h want %h", t.n, act, t.e);
    end
    tests++;
    if (InstRetired !== t.cnt) begin
      fails++;
      $display("FAIL %s retired: got %0d want %0d",
               t.n, InstRetired, t.cnt);
    end
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    rst = t.r;
    Opcode = t.opc;
    MemReady = t.mrdy;
    BranchTaken = t.bt;
    sb_q.push_back(t);
    #2;
    check();
  endtask

  initial begin
    // power-on reset, then reset row with MemReady high
    tbl.push_back(v("rst", 1, OP, 1, 0, F, 5'b00100, 0, 0, 0, 1, 2, 0));
    // ADD
    tbl.push_back(fe("add.f", OP, 1, 0));
    tbl.push_back(de("add.d", OP, 0));
    tbl.push_back(v("add.e", 0, OP, 1, 0, E, 5'b00000, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v("add.wb", 0, OP, 1, 0, W, 5'b00001, 0, 0, 0, 0, 0, 0));
    // LOAD with 3 fetch waits and 2 memory waits
    for (int i = 0; i < 3; i++) tbl.push_back(fe("ld.fw", LD, 0, 1));
    tbl.push_back(fe("ld.f", LD, 1, 1));
    tbl.push_back(de("ld.d", LD, 1));
    tbl.push_back(v("ld.e", 0, LD, 1, 0, E, 5'b00000, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 2; i++)
      tbl.push_back(v("ld.mw", 0, LD, 0, 0, M, 5'b00100, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v("ld.m", 0, LD, 1, 0, M, 5'b00100, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v("ld.wb", 0, LD, 1, 0, W, 5'b00001, 0, 1, 0, 0, 0, 1));
    // BEQ taken, then not taken
    tbl.push_back(fe("beq1.f", BR, 1, 2));
    tbl.push_back(de("beq1.d", BR, 2));
    tbl.push_back(v("beq1.e", 0, BR, 1, 1, E, 5'b01000, 1, 0, 1, 0, 0, 2));
    tbl.push_back(fe("beq0.f", BR, 1, 3));
    tbl.push_back(de("beq0.d", BR, 3));
    tbl.push_back(v("beq0.e", 0, BR, 1, 0, E, 5'b00000, 0, 0, 1, 0, 0, 3));
    // JALR, JAL
    tbl.push_back(fe("jalr.f", JR, 1, 4));
    tbl.push_back(de("jalr.d", JR, 4));
    tbl.push_back(v("jalr.e", 0, JR, 1, 0, E, 5'b01000, 2, 0, 0, 0, 1, 4));
    tbl.push_back(v("jalr.wb", 0, JR, 1, 0, W, 5'b00001, 0, 2, 0, 0, 0, 4));
    tbl.push_back(fe("jal.f", JAL, 1, 5));
    tbl.push_back(de("jal.d", JAL, 5));
    tbl.push_back(v("jal.e", 0, JAL, 1, 0, E, 5'b01000, 1, 0, 0, 2, 1, 5));
    tbl.push_back(v("jal.wb", 0, JAL, 1, 0, W, 5'b00001, 0, 2, 0, 0, 0, 5));
    // FENCE retires from DECODE
    tbl.push_back(fe("fence.f", FEN, 1, 6));
    tbl.push_back(de("fence.d", FEN, 6));
    // LUI, AUIPC, OP-IMM
    tbl.push_back(fe("lui.f", LUI, 1, 7));
    tbl.push_back(de("lui.d", LUI, 7));
    tbl.push_back(v("lui.e", 0, LUI, 1, 0, E, 5'b00000, 0, 0, 0, 3, 1, 7));
    tbl.push_back(v("lui.wb", 0, LUI, 1, 0, W, 5'b00001, 0, 0, 0, 0, 0, 7));
    tbl.push_back(fe("aui.f", AUI, 1, 8));
    tbl.push_back(de("aui.d", AUI, 8));
    tbl.push_back(v("aui.e", 0, AUI, 1, 0, E, 5'b00000, 0, 0, 0, 2, 1, 8));
    tbl.push_back(v("aui.wb", 0, AUI, 1, 0, W, 5'b00001, 0, 0, 0, 0, 0, 8));
    tbl.push_back(fe("opi.f", OPI, 1, 9));
    tbl.push_back(de("opi.d", OPI, 9));
    tbl.push_back(v("opi.e", 0, OPI, 1, 0, E, 5'b00000, 0, 0, 2, 0, 1, 9));
    tbl.push_back(v("opi.wb", 0, OPI, 1, 0, W, 5'b00001, 0, 0, 0, 0, 0, 9));
    // STORE with one memory wait
    tbl.push_back(fe("st.f", ST, 1, 10));
    tbl.push_back(de("st.d", ST, 10));
    tbl.push_back(v("st.e", 0, ST, 1, 0, E, 5'b00000, 0, 0, 0, 0, 1, 10));
    tbl.push_back(v("st.mw", 0, ST, 0, 0, M, 5'b00010, 0, 0, 0, 0, 1, 10));
    tbl.push_back(v("st.m", 0, ST, 1, 0, M, 5'b00010, 0, 0, 0, 0, 1, 10));
    // STORE abandoned by reset mid-handshake
    tbl.push_back(fe("st2.f", ST, 1, 11));
    tbl.push_back(de("st2.d", ST, 11));
    tbl.push_back(v("st2.e", 0, ST, 1, 0, E, 5'b00000, 0, 0, 0, 0, 1, 11));
    tbl.push_back(v("st2.mw", 0, ST, 0, 0, M, 5'b00010, 0, 0, 0, 0, 1, 11));
    tbl.push_back(v("st2.rst", 1, ST, 0, 0, M, 5'b00100, 0, 0, 0, 1, 2, 11));
    tbl.push_back(fe("post.f", ST, 0, 0));
    // ADD then ECALL
    tbl.push_back(fe("add2.f", OP, 1, 0));
    tbl.push_back(de("add2.d", OP, 0));
    tbl.push_back(v("add2.e", 0, OP, 1, 0, E, 5'b00000, 0, 0, 2, 0, 0, 0));
    tbl.push_back(v("add2.wb", 0, OP, 1, 0, W, 5'b00001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("ecall.f", SYS, 1, 1));
    tbl.push_back(de("ecall.d", SYS, 1));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // HALT is sticky and ignores handshake inputs
    for (int k = 0; k < 20; k++)
      step(v("halt", 0, SYS, 1'($urandom), 1'($urandom), H,
             5'b00000, 0, 0, 0, 0, 0, 1));
    step(v("halt.rst", 1, SYS, 1, 0, H, 5'b00100, 0, 0, 0, 1, 2, 1));
    step(fe("reboot.f", OP, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
